// File: rtl/print_buffer_pkg.sv
// Shared definitions for the print buffer: register offsets, default depth,
// FSM state types and the STATUS word layout.
package print_buffer_pkg;

    localparam int   PRINT_DEPTH    = 16;
    localparam logic PRINT_DATA_OFS = 1'b0;   // addr[2] value selecting DATA
    localparam logic PRINT_STAT_OFS = 1'b1;   // addr[2] value selecting STATUS

    typedef enum logic [1:0] {
        C_IDLE,
        C_PEND,
        C_RESP
    } core_state_t;

    typedef enum logic {
        D_IDLE,
        D_WAIT
    } drain_state_t;

    function automatic logic [31:0] status_word(input logic [7:0] level,
                                                input logic       full,
                                                input logic       empty);
        return {16'b0, level, 6'b0, full, empty};
    endfunction

endpackage

// File: rtl/print_fifo.sv
// Character FIFO: DEPTH x 8 storage with wrapping pointers and an occupancy
// count. Push and pop may happen in the same cycle, including when full.
module print_fifo
    import print_buffer_pkg::*;
#(
    parameter  int DEPTH = PRINT_DEPTH,
    localparam int CNT_W = $clog2(DEPTH) + 1,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [7:0]       push_data,
    input  logic             pop,
    output logic [7:0]       head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] level;

    // NOTE: the storage array has no reset; pointers and count alone define
    // which entries are valid, and a reset-free array can map onto RAM.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: all state flops use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            // DEPTH is a power of two, so plain increment wraps the pointers.
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + CNT_W'(1);
                2'b01:   level <= level - CNT_W'(1);
                default: level <= level;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign count = level;
    assign full  = (level == CNT_W'(DEPTH));
    assign empty = (level == '0);

endmodule

// File: rtl/print_buffer.sv
// Print buffer: accepts character writes from the core bus, queues them and
// forwards them one at a time to the print sink; STATUS exposes the fill level.
module print_buffer
    import print_buffer_pkg::*;
#(
    parameter  int DEPTH = PRINT_DEPTH,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_valid,
    input  logic        cpu_instr,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_wstrb,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ready,
    output logic        print_valid,
    output logic        print_instr,
    output logic [31:0] print_addr,
    output logic [31:0] print_wdata,
    output logic [3:0]  print_wstrb,
    input  logic [31:0] print_rdata,
    input  logic        print_ready
);

    core_state_t      c_state, c_next;
    drain_state_t     d_state, d_next;
    logic [7:0]       pend_char;
    logic [7:0]       held_char;
    logic [7:0]       fifo_head;
    logic [7:0]       push_data;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full, fifo_empty;
    logic             push, pop, send;
    logic             accept, is_write, is_data, is_stat, wr_char, space;
    logic             unused_ok;

    assign accept   = (c_state == C_IDLE) && cpu_valid;
    assign is_write = |cpu_wstrb;
    assign is_data  = (cpu_addr[2] == PRINT_DATA_OFS);
    assign is_stat  = (cpu_addr[2] == PRINT_STAT_OFS);
    assign wr_char  = accept && !cpu_instr && is_data && cpu_wstrb[0];

    // A char stays queued until the sink completes it, so the count includes
    // the one in flight and a completion frees its slot in the same cycle.
    assign pop   = (d_state == D_WAIT) && print_ready;
    assign space = !fifo_full || pop;

    print_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        // NOTE: every combinational output is defaulted first so no path can
        // leave it unassigned and infer a latch.
        c_next    = c_state;
        push      = 1'b0;
        push_data = cpu_wdata[7:0];
        unique case (c_state)
            C_IDLE: begin
                if (accept) begin
                    push   = wr_char && space;
                    c_next = (wr_char && !space) ? C_PEND : C_RESP;
                end
            end
            C_PEND: begin
                push_data = pend_char;
                if (space) begin
                    push   = 1'b1;
                    c_next = C_RESP;
                end
            end
            C_RESP:  c_next = C_IDLE;
            default: c_next = C_IDLE;
        endcase
    end

    always_comb begin
        d_next = d_state;
        send   = 1'b0;
        unique case (d_state)
            D_IDLE: begin
                if (!fifo_empty) begin
                    send   = 1'b1;
                    d_next = D_WAIT;
                end
            end
            D_WAIT: begin
                if (print_ready) begin
                    d_next = D_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            c_state   <= C_IDLE;
            d_state   <= D_IDLE;
            pend_char <= '0;
            held_char <= '0;
            cpu_rdata <= '0;
        end else begin
            c_state <= c_next;
            d_state <= d_next;
            if (accept) begin
                pend_char <= cpu_wdata[7:0];
                cpu_rdata <= (is_stat && !is_write && !cpu_instr)
                             ? status_word(8'(fifo_count), fifo_full, fifo_empty)
                             : '0;
            end else if (c_state == C_RESP) begin
                cpu_rdata <= '0;
            end
            if (send) begin
                held_char <= fifo_head;
            end
        end
    end

    assign cpu_ready   = (c_state == C_RESP);
    assign print_valid = send;
    assign print_instr = 1'b0;
    assign print_addr  = '0;
    assign print_wstrb = 4'b0001;
    assign print_wdata = {24'b0, send ? fifo_head : held_char};

    // Bus bits this slave never decodes.
    assign unused_ok = ^{print_rdata, cpu_addr[31:3], cpu_addr[1:0], cpu_wdata[31:8]};

endmodule

// File: tb/tb_print_buffer.sv
// Scoreboard bench for print_buffer: requests queue their expected responses,
// a monitor compares whatever the DUT presents on either side.
module tb_print_buffer;
    import print_buffer_pkg::*;

    localparam int DEPTH = PRINT_DEPTH;

    logic        clock = 1'b0;
    logic        reset;
    logic        cpu_valid, cpu_instr;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic [3:0]  cpu_wstrb;
    logic        cpu_ready;
    logic        print_valid, print_instr, print_ready;
    logic [31:0] print_addr, print_wdata, print_rdata;
    logic [3:0]  print_wstrb;

    int total = 0;
    int bad   = 0;

    logic [31:0] cpu_exp [$];
    logic [7:0]  print_exp [$];
    int acks = 0, ack_cycle = 0, cycle = 0;
    int sent = 0, readies = 0;
    int sink_credits = 0;
    bit sink_auto = 1'b0;
    bit stray = 1'b0;
    int level = 0;  // chars written but not yet completed by the sink

    print_buffer dut (
        .clock       (clock),
        .reset       (reset),
        .cpu_valid   (cpu_valid),
        .cpu_instr   (cpu_instr),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_wstrb   (cpu_wstrb),
        .cpu_rdata   (cpu_rdata),
        .cpu_ready   (cpu_ready),
        .print_valid (print_valid),
        .print_instr (print_instr),
        .print_addr  (print_addr),
        .print_wdata (print_wdata),
        .print_wstrb (print_wstrb),
        .print_rdata (print_rdata),
        .print_ready (print_ready)
    );

    always #5 clock = ~clock;

    initial forever begin
        @(posedge clock);
        cycle++;
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] required);
        total++;
        if (actual !== required) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", name, actual, required);
        end
    endtask

    function automatic logic [31:0] exp_status(input int lvl);
        logic [31:0] w;
        w = 32'(lvl) << 8;
        if (lvl == DEPTH) w[1] = 1'b1;
        if (lvl == 0)     w[0] = 1'b1;
        return w;
    endfunction

    // Monitor: one comparison per response pulse on either side.
    initial forever begin
        @(negedge clock);
        if (reset === 1'b0) begin
            if (cpu_ready) begin
                acks++;
                ack_cycle = cycle;
                if (cpu_exp.size() == 0) check("cpu_extra_ack", 32'(cpu_ready), 32'h0);
                else                     check("cpu_rdata", cpu_rdata, cpu_exp.pop_front());
            end
            if (print_valid) begin
                sent++;
                check("print_addr", print_addr, 32'h0);
                check("print_ctl", {27'b0, print_instr, print_wstrb}, 32'h1);
                if (print_exp.size() == 0) check("print_extra", 32'(print_valid), 32'h0);
                else                       check("print_char", print_wdata, {24'b0, print_exp.pop_front()});
            end
        end
    end

    // Sink: completes each request one cycle after it appears, when allowed.
    initial begin
        print_ready = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            if (stray) begin
                print_ready = 1'b1;
                stray = 1'b0;
            end else if (sent > readies && (sink_auto || sink_credits > 0)) begin
                print_ready = 1'b1;
                readies++;
                level--;
                if (!sink_auto) sink_credits--;
            end else begin
                print_ready = 1'b0;
            end
        end
    end

    task automatic cpu_issue(input bit stat, input bit instr, input logic [3:0] strb,
                             input logic [31:0] wdata, input logic [31:0] exp_rdata,
                             output int a0, output int c0);
        cpu_exp.push_back(exp_rdata);
        if (!instr && !stat && strb[0]) begin
            print_exp.push_back(wdata[7:0]);
            level++;
        end
        @(posedge clock);
        #1;
        cpu_valid = 1'b1;
        cpu_instr = instr;
        cpu_wstrb = strb;
        cpu_wdata = wdata;
        cpu_addr  = ($urandom() & 32'hFFFF_FFFB) | (stat ? 32'h4 : 32'h0);
        a0 = acks;
        c0 = cycle;
        @(posedge clock);
        #1;
        cpu_valid = 1'b0;
        cpu_instr = 1'b0;
        cpu_wstrb = 4'($urandom());
        cpu_wdata = $urandom();
        cpu_addr  = $urandom();
    endtask

    task automatic cpu_wait(input int a0, input int c0, input bit fast);
        int n = 0;
        while (acks == a0 && n < 300) begin
            @(posedge clock);
            n++;
        end
        check("ack_count", acks - a0, 32'd1);
        if (fast) check("ack_latency", ack_cycle - c0, 32'd1);
    endtask

    task automatic cpu_req(input bit stat, input bit instr, input logic [3:0] strb,
                           input logic [31:0] wdata, input logic [31:0] exp_rdata, input bit fast);
        int a0, c0;
        cpu_issue(stat, instr, strb, wdata, exp_rdata, a0, c0);
        cpu_wait(a0, c0, fast);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((print_exp.size() != 0 || sent != readies) && n < 3000) begin
            @(posedge clock);
            n++;
        end
        repeat (2) @(posedge clock);
        check("drain_left", print_exp.size(), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a0, c0, s0, chars, kind;
        reset       = 1'b1;
        cpu_valid   = 1'b0;
        cpu_instr   = 1'b0;
        cpu_addr    = '0;
        cpu_wdata   = '0;
        cpu_wstrb   = '0;
        print_rdata = 32'hDEAD_BEEF;
        repeat (3) @(posedge clock);
        #2;
        check("rst_rdata", cpu_rdata, 32'h0);
        check("rst_wdata", print_wdata, 32'h0);
        check("rst_flags", {30'b0, cpu_ready, print_valid}, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        cpu_req(1'b1, 1'b0, 4'b0000, $urandom(), 32'h0000_0001, 1'b1);

        // Single char: ack and sink request both appear the cycle after the push.
        sink_auto = 1'b1;
        cpu_issue(1'b0, 1'b0, 4'b0001, 32'h1234_5641, 32'h0, a0, c0);
        check("single_ready", 32'(cpu_ready), 32'h1);
        check("single_pvalid", 32'(print_valid), 32'h1);
        check("single_pwdata", print_wdata, 32'h41);
        cpu_wait(a0, c0, 1'b1);
        wait_drain();

        // Strobes, reads, fetch, STATUS write: all ack with 0, none reach the sink.
        s0 = sent;
        cpu_req(1'b0, 1'b0, 4'b0010, 32'h0000_0042, 32'h0, 1'b1);
        cpu_req(1'b0, 1'b0, 4'b0000, $urandom(), 32'h0, 1'b1);
        cpu_req(1'b1, 1'b1, 4'b0000, $urandom(), 32'h0, 1'b1);
        cpu_req(1'b1, 1'b0, 4'b1111, 32'h0000_0055, 32'h0, 1'b1);
        repeat (4) @(posedge clock);
        check("no_print", sent - s0, 32'd0);
        cpu_req(1'b1, 1'b0, 4'b0000, 32'h0, 32'h0000_0001, 1'b1);

        // Status with a stalled sink.
        sink_auto = 1'b0;
        for (int i = 0; i < 3; i++) cpu_req(1'b0, 1'b0, 4'b0001, 32'h30 + i, 32'h0, 1'b1);
        cpu_req(1'b1, 1'b0, 4'b0000, 32'h0, 32'h0000_0300, 1'b1);
        sink_auto = 1'b1;
        wait_drain();

        // Fill: 'a'..'p' fill the FIFO, 'q' stalls until one completion.
        sink_auto = 1'b0;
        for (int i = 0; i < DEPTH; i++) cpu_req(1'b0, 1'b0, 4'b0001, 32'h61 + i, 32'h0, 1'b1);
        cpu_req(1'b1, 1'b0, 4'b0000, 32'h0, 32'h0000_1002, 1'b1);
        cpu_issue(1'b0, 1'b0, 4'b0001, 32'h61 + DEPTH, 32'h0, a0, c0);
        repeat (10) @(posedge clock);
        check("pend_stall", acks - a0, 32'd0);
        sink_credits = 1;
        cpu_wait(a0, c0, 1'b0);
        cpu_req(1'b1, 1'b0, 4'b0000, 32'h0, exp_status(level), 1'b1);
        sink_auto = 1'b1;
        wait_drain();
        cpu_req(1'b1, 1'b0, 4'b0000, 32'h0, 32'h0000_0001, 1'b1);

        // Back-to-back random traffic with a prompt sink.
        s0 = sent;
        chars = 0;
        while (chars < 100) begin
            kind = $urandom_range(0, 9);
            repeat ($urandom_range(0, 2)) @(posedge clock);
            case (kind)
                0: cpu_req(1'b0, 1'b0, 4'b0000, $urandom(), 32'h0, 1'b1);
                1: cpu_req(1'($urandom_range(0, 1)), 1'b1, 4'($urandom()), $urandom(), 32'h0, 1'b1);
                2: cpu_req(1'b0, 1'b0, 4'($urandom()) & 4'b1110, $urandom(), 32'h0, 1'b1);
                3: cpu_req(1'b1, 1'b0, 4'($urandom()) | 4'b0001, $urandom(), 32'h0, 1'b1);
                default: begin
                    cpu_req(1'b0, 1'b0, 4'($urandom()) | 4'b0001, $urandom(), 32'h0, 1'b0);
                    chars++;
                end
            endcase
        end
        wait_drain();
        check("b2b_count", sent - s0, 32'd100);
        cpu_req(1'b1, 1'b0, 4'b0000, 32'h0, 32'h0000_0001, 1'b1);

        // Reset with chars queued and one in flight at the sink.
        sink_auto = 1'b0;
        for (int i = 0; i < 3; i++) cpu_req(1'b0, 1'b0, 4'b0001, 32'h70 + i, 32'h0, 1'b1);
        @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        check("mid_rst_rdata", cpu_rdata, 32'h0);
        check("mid_rst_wdata", print_wdata, 32'h0);
        check("mid_rst_flags", {30'b0, cpu_ready, print_valid}, 32'h0);
        cpu_exp.delete();
        print_exp.delete();
        level   = 0;
        sent    = 0;
        readies = 0;
        sink_credits = 0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        stray = 1'b1;
        repeat (3) @(posedge clock);
        cpu_req(1'b1, 1'b0, 4'b0000, 32'h0, 32'h0000_0001, 1'b1);
        repeat (5) @(posedge clock);
        check("post_rst_print", sent, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
